// File: rtl/irq_ctrl_if.sv
// Register-access bus between the CPU-side master and the interrupt controller.
// One sel pulse is one access; rdata follows addr combinationally.
interface irq_ctrl_if;
    logic       sel;
    logic       we;
    logic [2:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;

    modport master (
        output sel,
        output we,
        output addr,
        output wdata,
        input  rdata
    );

    modport slave (
        input  sel,
        input  we,
        input  addr,
        input  wdata,
        output rdata
    );
endinterface

// File: rtl/irq_ctrl.sv
// Prioritised interrupt controller: per-source level/edge capture, masking,
// and an IDLE/ASSERT/SERVICE handshake with the CPU via claim (VEC) and EOI.
module irq_ctrl #(
    parameter int NSRC = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] irq_src,
    irq_ctrl_if.slave       bus,
    output logic            intr
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    localparam logic [7:0] VMASK  = 8'((9'd1 << NSRC) - 9'd1);
    localparam logic [2:0] A_PEND = 3'd0;
    localparam logic [2:0] A_MASK = 3'd1;
    localparam logic [2:0] A_EDGE = 3'd2;
    localparam logic [2:0] A_ACK  = 3'd3;
    localparam logic [2:0] A_VEC  = 3'd4;
    localparam logic [2:0] A_CTRL = 3'd5;
    localparam logic [2:0] A_EOI  = 3'd6;

    // Lowest set index wins (index 0 is highest priority).
    function automatic logic [2:0] prio_enc(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) begin
                idx = 3'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    state_t     state_q, state_d;
    logic       intr_q, intr_d;
    logic [2:0] isr_q, isr_d;
    logic [7:0] pend_q, pend_d;
    logic [7:0] src_prev_q, src_prev_d;
    logic [7:0] mask_q, mask_d;
    logic [7:0] edge_q, edge_d;
    logic       gen_q, gen_d;

    logic [7:0] src_ext_s;
    logic       wr_s;
    logic       vec_rd_s;
    logic       eoi_s;
    logic [7:0] act_s;
    logic       act_any_s;
    logic [2:0] win_s;
    logic [7:0] vec_s;
    logic [7:0] clr_s;
    logic [7:0] rise_s;
    logic [7:0] rdata_s;

    assign src_ext_s = 8'(irq_src) & VMASK;

    // Access decode, active set, winner and vector value.
    always_comb begin
        wr_s      = bus.sel & bus.we;
        vec_rd_s  = bus.sel & ~bus.we & (bus.addr == A_VEC);
        eoi_s     = wr_s & (bus.addr == A_EOI) & (state_q == ST_SERVICE);
        act_s     = pend_q & mask_q;
        act_any_s = (act_s != 8'h00);
        win_s     = prio_enc(act_s);
        if (act_any_s) begin
            vec_s = {1'b1, 4'b0000, win_s};
        end else begin
            vec_s = 8'h00;
        end
    end

    // Pending capture: a new edge beats any same-cycle ACK/EOI clear.
    always_comb begin
        clr_s = 8'h00;
        if (wr_s && (bus.addr == A_ACK)) begin
            clr_s = bus.wdata & VMASK;
        end else begin
            clr_s = 8'h00;
        end
        if (eoi_s) begin
            clr_s = clr_s | (8'h01 << isr_q);
        end else begin
            clr_s = clr_s;
        end
        rise_s     = src_ext_s & ~src_prev_q;
        pend_d     = ((edge_q & (rise_s | (pend_q & ~clr_s))) | (~edge_q & src_ext_s)) & VMASK;
        src_prev_d = src_ext_s;
    end

    // Configuration register writes; bits above NSRC never stick.
    always_comb begin
        mask_d = mask_q;
        edge_d = edge_q;
        gen_d  = gen_q;
        if (wr_s) begin
            case (bus.addr)
                A_MASK:  mask_d = bus.wdata & VMASK;
                A_EDGE:  edge_d = bus.wdata & VMASK;
                A_CTRL:  gen_d  = bus.wdata[0];
                default: mask_d = mask_q;
            endcase
        end else begin
            mask_d = mask_q;
        end
    end

    // Handshake FSM next state; intr is high only while in ASSERT.
    always_comb begin
        state_d = state_q;
        intr_d  = 1'b0;
        isr_d   = isr_q;
        case (state_q)
            ST_IDLE: begin
                if (gen_q && act_any_s) begin
                    state_d = ST_ASSERT;
                    intr_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ASSERT: begin
                // Withdrawal takes precedence so a racing claim sees 0x00.
                if (!gen_q || !act_any_s) begin
                    state_d = ST_IDLE;
                end else if (vec_rd_s) begin
                    state_d = ST_SERVICE;
                    isr_d   = win_s;
                end else begin
                    intr_d  = 1'b1;
                end
            end
            ST_SERVICE: begin
                if (eoi_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_SERVICE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Read mux; forced to zero while reset is held.
    always_comb begin
        rdata_s = 8'h00;
        if (rst) begin
            rdata_s = 8'h00;
        end else begin
            case (bus.addr)
                A_PEND:  rdata_s = pend_q;
                A_MASK:  rdata_s = mask_q;
                A_EDGE:  rdata_s = edge_q;
                A_VEC:   rdata_s = vec_s;
                A_CTRL:  rdata_s = {7'b0000000, gen_q};
                default: rdata_s = 8'h00;
            endcase
        end
    end

    assign bus.rdata = rdata_s;
    assign intr      = intr_q;

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            intr_q     <= 1'b0;
            isr_q      <= 3'd0;
            pend_q     <= 8'h00;
            src_prev_q <= 8'h00;
            mask_q     <= 8'h00;
            edge_q     <= 8'h00;
            gen_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            intr_q     <= intr_d;
            isr_q      <= isr_d;
            pend_q     <= pend_d;
            src_prev_q <= src_prev_d;
            mask_q     <= mask_d;
            edge_q     <= edge_d;
            gen_q      <= gen_d;
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: edge/level paths, priority, withdrawal,
// ACK collision, masking/GEN and reset during service.
module tb_irq_ctrl;

    localparam logic [2:0] A_PEND = 3'd0;
    localparam logic [2:0] A_MASK = 3'd1;
    localparam logic [2:0] A_EDGE = 3'd2;
    localparam logic [2:0] A_ACK  = 3'd3;
    localparam logic [2:0] A_VEC  = 3'd4;
    localparam logic [2:0] A_CTRL = 3'd5;
    localparam logic [2:0] A_EOI  = 3'd6;
    localparam logic [2:0] A_RSV  = 3'd7;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] irq_src;
    logic       intr;
    int         n_checks = 0;
    int         n_errors = 0;

    irq_ctrl_if bus_if ();

    irq_ctrl #(.NSRC(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .irq_src (irq_src),
        .bus     (bus_if),
        .intr    (intr)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reg_wr(input logic [2:0] a, input logic [7:0] d);
        bus_if.sel   = 1'b1;
        bus_if.we    = 1'b1;
        bus_if.addr  = a;
        bus_if.wdata = d;
        step();
        bus_if.sel   = 1'b0;
        bus_if.we    = 1'b0;
    endtask

    task automatic reg_rd(input string tag, input logic [2:0] a, input logic [7:0] exp);
        bus_if.sel  = 1'b1;
        bus_if.we   = 1'b0;
        bus_if.addr = a;
        #1;
        check_val(tag, bus_if.rdata, exp);
        step();
        bus_if.sel  = 1'b0;
    endtask

    task automatic peek(input string tag, input logic [2:0] a, input logic [7:0] exp);
        bus_if.sel  = 1'b0;
        bus_if.addr = a;
        #1;
        check_val(tag, bus_if.rdata, exp);
    endtask

    task automatic check_intr(input string tag, input logic exp);
        check_val(tag, {7'b0000000, intr}, {7'b0000000, exp});
    endtask

    task automatic check_all_zero(input string tag);
        for (int a = 0; a < 8; a++) begin
            peek($sformatf("%s_reg%0d", tag, a), 3'(a), 8'h00);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst          = 1'b1;
        irq_src      = 8'h00;
        bus_if.sel   = 1'b0;
        bus_if.we    = 1'b0;
        bus_if.addr  = 3'd0;
        bus_if.wdata = 8'h00;
        step();
        step();
        check_intr("reset_intr", 1'b0);
        check_all_zero("reset");
        rst = 1'b0;
        step();
        check_all_zero("post_reset");

        // Reserved register and CTRL upper bits.
        reg_wr(A_RSV, 8'hFF);
        peek("rsv_read", A_RSV, 8'h00);
        reg_wr(A_CTRL, 8'hFE);
        peek("ctrl_bit0_only", A_CTRL, 8'h00);

        // Edge path on source 0.
        reg_wr(A_MASK, 8'h01);
        reg_wr(A_EDGE, 8'h01);
        reg_wr(A_CTRL, 8'h01);
        peek("edge_mask_rb", A_MASK, 8'h01);
        irq_src = 8'h01;
        step();
        irq_src = 8'h00;
        peek("edge_pend_n1", A_PEND, 8'h01);
        check_intr("edge_intr_n1", 1'b0);
        step();
        check_intr("edge_intr_n2", 1'b1);
        reg_rd("edge_vec", A_VEC, 8'h80);
        check_intr("edge_intr_claimed", 1'b0);
        peek("edge_pend_held", A_PEND, 8'h01);
        reg_wr(A_EOI, 8'h00);
        peek("edge_pend_eoi", A_PEND, 8'h00);
        check_intr("edge_intr_eoi", 1'b0);
        step();
        check_intr("edge_intr_after", 1'b0);

        // Edge set collides with ACK clear; then ACK alone clears.
        reg_wr(A_CTRL, 8'h00);
        reg_wr(A_EDGE, 8'h03);
        irq_src = 8'h02;
        reg_wr(A_ACK, 8'h02);
        irq_src = 8'h00;
        peek("ack_collide", A_PEND, 8'h02);
        reg_wr(A_ACK, 8'h02);
        peek("ack_clear", A_PEND, 8'h00);

        // Edge-to-level switch discards a stored edge one cycle after the write.
        irq_src = 8'h02;
        step();
        irq_src = 8'h00;
        reg_wr(A_EDGE, 8'h00);
        peek("e2l_write_cycle", A_PEND, 8'h02);
        step();
        peek("e2l_discard", A_PEND, 8'h00);

        // Priority among level sources 2 and 5.
        reg_wr(A_MASK, 8'h24);
        irq_src = 8'h24;
        reg_wr(A_CTRL, 8'h01);
        step();
        check_intr("prio_intr1", 1'b1);
        reg_rd("prio_vec1", A_VEC, 8'h82);
        check_intr("prio_claim1", 1'b0);
        reg_wr(A_EOI, 8'h00);
        check_intr("prio_idle_gap", 1'b0);
        step();
        check_intr("prio_intr2", 1'b1);
        reg_rd("prio_vec2", A_VEC, 8'h82);
        irq_src = 8'h20;
        reg_wr(A_EOI, 8'h00);
        check_intr("prio_idle_gap2", 1'b0);
        step();
        check_intr("prio_intr3", 1'b1);
        reg_rd("prio_vec3", A_VEC, 8'h85);
        irq_src = 8'h00;
        reg_wr(A_EOI, 8'h00);
        step();
        check_intr("prio_quiet", 1'b0);

        // Spurious withdrawal of level source 3.
        irq_src = 8'h08;
        reg_wr(A_MASK, 8'h08);
        step();
        check_intr("spur_intr", 1'b1);
        irq_src = 8'h00;
        step();
        reg_rd("spur_vec", A_VEC, 8'h00);
        check_intr("spur_drop", 1'b0);
        irq_src = 8'h08;
        step();
        step();
        check_intr("spur_not_claimed", 1'b1);
        irq_src = 8'h00;
        step();
        step();
        check_intr("spur_quiet", 1'b0);

        // Masking and GEN with source 4.
        reg_wr(A_MASK, 8'h00);
        irq_src = 8'h10;
        step();
        step();
        check_intr("mask_blocked", 1'b0);
        peek("mask_pend", A_PEND, 8'h10);
        reg_wr(A_MASK, 8'h10);
        check_intr("mask_n1", 1'b0);
        step();
        check_intr("mask_n2", 1'b1);
        reg_wr(A_CTRL, 8'h00);
        step();
        check_intr("gen_off", 1'b0);
        peek("gen_ctrl_rb", A_CTRL, 8'h00);
        irq_src = 8'h00;
        step();

        // Reset during SERVICE.
        reg_wr(A_MASK, 8'h01);
        reg_wr(A_EDGE, 8'h01);
        reg_wr(A_CTRL, 8'h01);
        irq_src = 8'h01;
        step();
        irq_src = 8'h00;
        step();
        reg_rd("rst_claim_vec", A_VEC, 8'h80);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_intr("rst_mid_intr", 1'b0);
        check_all_zero("rst_mid");
        reg_wr(A_EOI, 8'h00);
        step();
        check_intr("rst_eoi_intr", 1'b0);
        check_all_zero("rst_eoi");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
